// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: widths, the collector FSM state type,
// and saturation/ReLU helpers that later requantizers can reuse.
package cnn_pkg;

  localparam int PSUM_W = 20;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  typedef enum logic {
    ACC  = 1'b0,
    POST = 1'b1
  } state_t;

  // Clamp an ACC_W+1 signed sum back into ACC_W signed range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
    if (x[ACC_W] != x[ACC_W-1])
      return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return x[ACC_W-1:0];
  endfunction

  // Negative values become zero; the result is a non-negative magnitude.
  function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
    return x[ACC_W-1] ? '0 : x;
  endfunction

  // Clamp a non-negative ACC_W value to the unsigned pixel range.
  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] x);
    return (|x[ACC_W-1:OUT_W]) ? '1 : x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Small synchronous FIFO holding finished ofmap pixels. The head word is
// presented combinationally from registered storage; reads as zero when empty.
module psum_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign valid   = (count != '0);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care until a push lands.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psum_collector.sv
// Bottom-of-column partial-sum collector: accumulates cfg_num_pass psums per
// pixel, then bias + ReLU + shift + saturate into an 8-bit output FIFO.
// Build option: define PSUM_ROUND_EN for round-half-up on the right shift.
module psum_collector
  import cnn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic                     psum_ready,
  input  logic                     clear,
  input  logic [3:0]               cfg_num_pass,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic [4:0]               cfg_shift,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  logic                    rdy_en;
  logic signed [ACC_W-1:0] acc_p0;
  logic [3:0]              pass_cnt;
  logic signed [ACC_W-1:0] res_p1, bias_p1;
  logic [4:0]              shift_p1;
  logic                    vld_p1;
  logic [CNT_W-1:0]        fifo_count;
  logic                    accept, last_pass;
  logic [3:0]              pass_last;
  logic signed [ACC_W:0]   sum_w, biased_w;
  logic signed [ACC_W-1:0] acc_sum;
  logic [OUT_W-1:0]        pix_p1;

  // Right shift of a non-negative value, optionally rounding half-up.
  function automatic logic [ACC_W-1:0] shift_round(input logic [ACC_W-1:0] x,
                                                   input logic [4:0]       sh);
`ifdef PSUM_ROUND_EN
    logic [ACC_W-1:0] half;
    half = '0;
    if (sh != 5'd0) half = ACC_W'(1) << (sh - 5'd1);
    return (x + half) >> sh;
`else
    return x >> sh;
`endif
  endfunction

  assign accept     = psum_valid & psum_ready;
  assign pass_last  = (cfg_num_pass == 4'd0) ? 4'd0 : cfg_num_pass - 4'd1;
  assign last_pass  = (pass_cnt == pass_last);
  assign psum_ready = rdy_en & (state == ACC) & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign busy       = (pass_cnt != 4'd0) | (state == POST) | (fifo_count != '0);

  // ---- stage p0: accumulate incoming psums ----
  assign sum_w   = $signed({acc_p0[ACC_W-1], acc_p0})
                 + $signed({{(ACC_W+1-PSUM_W){psum_in[PSUM_W-1]}}, psum_in});
  assign acc_sum = sat_acc(sum_w);

  // Ready is held low through reset and enabled on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Accumulator FSM: ACC gathers passes, POST spends one cycle pushing the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc_p0   <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        ACC: begin
          if (clear) begin
            acc_p0   <= '0;
            pass_cnt <= '0;
          end else if (accept) begin
            if (last_pass) begin
              acc_p0   <= '0;
              pass_cnt <= '0;
              state    <= POST;
            end else begin
              acc_p0   <= acc_sum;
              pass_cnt <= pass_cnt + 4'd1;
            end
          end
        end
        POST:    state <= ACC;
        default: state <= ACC;
      endcase
    end
  end

  // ---- stage p1: pre-bias result and its cfg snapshot, taken on the final pass ----
  always_ff @(posedge clk) begin
    if (accept && !clear && last_pass) begin
      res_p1   <= acc_sum;
      bias_p1  <= cfg_bias;
      shift_p1 <= cfg_shift;
    end
  end

  assign vld_p1   = (state == POST);
  assign biased_w = $signed({res_p1[ACC_W-1], res_p1})
                  + $signed({bias_p1[ACC_W-1], bias_p1});
  assign pix_p1   = sat_out(shift_round(relu(sat_acc(biased_w)), shift_p1));

  // ---- stage p2: output buffering toward the writer ----
  psum_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p1),
    .din   (pix_p1),
    .pop   (out_ready),
    .dout  (out_data),
    .valid (out_valid),
    .count (fifo_count)
  );

endmodule
